// File: rtl/ahb_master_if.sv
// AHB-Lite bus bundle between the two-port arbiter (master) and a slave.
// The master modport drives address/control/write data; the slave side
// returns ready, response and read data.
interface ahb_if;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;

   modport ahb_m (
      output HTRANS, HWRITE, HADDR, HWDATA, HSIZE, HBURST, HPROT, HMASTLOCK,
      input  HREADY, HRESP, HRDATA
   );

   modport ahb_s (
      input  HTRANS, HWRITE, HADDR, HWDATA, HSIZE, HBURST, HPROT, HMASTLOCK,
      output HREADY, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-requester AHB-Lite master: port 0 (data side) and port 1 (instruction
// side) share one bus. Each granted request becomes one non-pipelined SINGLE
// transfer (IDLE -> ADDR -> DATA), and completion is a one-cycle busy drop.
module ahb_master_arbiter #(
   parameter int         RR_ENABLE = 1,
   parameter logic [3:0] HPROT_P0  = 4'b0011,
   parameter logic [3:0] HPROT_P1  = 4'b0010
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  req_ren,
   input  logic [1:0]  req_wen,
   input  logic [31:0] req_addr0,
   input  logic [31:0] req_addr1,
   input  logic [31:0] req_wdata0,
   input  logic [31:0] req_wdata1,
   input  logic [3:0]  req_byte_en0,
   input  logic [3:0]  req_byte_en1,
   output logic [31:0] rdata,
   output logic [1:0]  busy,
   output logic [1:0]  err,
   ahb_if.ahb_m        ahb_m
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t      state_q, state_d;
   logic        last_grant_q;
   logic        grant_q;
   logic        write_q;
   logic [31:0] haddr_q;
   logic [31:0] wdata_q;
   logic [2:0]  hsize_q;

   logic [1:0]  pend;
   logic        sel;
   logic        take;
   logic        done;
   logic [1:0]  htrans;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic [4:0]  dec;
   logic        addr_unused;

   // Byte lanes to {HSIZE, HADDR[1:0]}; unsupported patterns fall back to a word.
   function automatic logic [4:0] be_decode(input logic [3:0] be);
      case (be)
         4'b1111: return {3'b010, 2'b00};
         4'b0011: return {3'b001, 2'b00};
         4'b1100: return {3'b001, 2'b10};
         4'b0001: return {3'b000, 2'b00};
         4'b0010: return {3'b000, 2'b01};
         4'b0100: return {3'b000, 2'b10};
         4'b1000: return {3'b000, 2'b11};
         default: return {3'b010, 2'b00};
      endcase
   endfunction

   assign pend      = req_ren | req_wen;
   assign sel       = ((RR_ENABLE != 0) && (pend == 2'b11)) ? ~last_grant_q : ~pend[0];
   assign sel_addr  = sel ? req_addr1    : req_addr0;
   assign sel_wdata = sel ? req_wdata1   : req_wdata0;
   assign sel_be    = sel ? req_byte_en1 : req_byte_en0;
   assign dec       = be_decode(sel_be);

   // Word-aligned request addresses and the HRESP upper bit carry no information here.
   assign addr_unused = ^{ahb_m.HRESP[1], req_addr0[1:0], req_addr1[1:0]};

   // State, arbitration history and the latched transfer attributes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         write_q      <= 1'b0;
         haddr_q      <= '0;
         wdata_q      <= '0;
         hsize_q      <= 3'b010;
      end else begin
         state_q <= state_d;
         if (take) begin
            grant_q <= sel;
            write_q <= req_wen[sel];
            haddr_q <= {sel_addr[31:2], dec[1:0]};
            wdata_q <= sel_wdata;
            hsize_q <= dec[4:2];
         end
         if (done) begin
            last_grant_q <= grant_q;
         end
      end
   end

   // Next state, bus transfer type and the per-port completion outputs.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      done    = 1'b0;
      htrans  = HTRANS_IDLE;
      busy    = 2'b11;
      err     = 2'b00;
      rdata   = '0;
      case (state_q)
         IDLE: begin
            if (|pend) begin
               take    = 1'b1;
               state_d = ADDR;
            end
         end
         ADDR: begin
            htrans = HTRANS_NONSEQ;
            if (ahb_m.HREADY) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (ahb_m.HREADY) begin
               done          = 1'b1;
               busy[grant_q] = 1'b0;
               err[grant_q]  = ahb_m.HRESP[0];
               rdata         = ahb_m.HRDATA;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ahb_m.HTRANS    = htrans;
   assign ahb_m.HWRITE    = write_q;
   assign ahb_m.HADDR     = haddr_q;
   assign ahb_m.HWDATA    = wdata_q;
   assign ahb_m.HSIZE     = hsize_q;
   assign ahb_m.HBURST    = 3'b000;
   assign ahb_m.HPROT     = grant_q ? HPROT_P1 : HPROT_P0;
   assign ahb_m.HMASTLOCK = 1'b0;

endmodule
